// File: rtl/fifo_test_pattern_gen_if.sv
// Write-side stream handshake between the pattern generator and the FIFO
// write port. The master drives the stream word and its valid flag; the
// slave answers with wr_ready.
interface fifo_test_pattern_gen_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] wr_data;
  logic              wr_data_valid;
  logic              wr_ready;

  modport master (
    output wr_data,
    output wr_data_valid,
    input  wr_ready
  );

  modport slave (
    input  wr_data,
    input  wr_data_valid,
    output wr_ready
  );
endinterface

// File: rtl/fifo_test_pattern_gen.sv
// Incrementing-word traffic source for the DDR FIFO test path.
// A run starts from INIT_VALUE and emits consecutive words (modulo 2^DATA_W)
// under a valid/ready handshake. Runs are bounded by word_count or continuous
// until stop. An optional idle gap follows every non-final accepted word.
// The run statistics report accepted words and how many all-ones words were
// accepted.
module fifo_test_pattern_gen #(
  parameter int                DATA_W     = 32,
  parameter logic [DATA_W-1:0] INIT_VALUE = {DATA_W{1'b0}},
  parameter int                GAP_W      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    continuous,
  input  logic [31:0]             word_count,
  input  logic [GAP_W-1:0]        gap_cycles,
  fifo_test_pattern_gen_if.master wr_if,
  output logic                    busy,
  output logic                    done,
  output logic [31:0]             words_sent,
  output logic [31:0]             wrap_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t            state_r;
  logic [DATA_W-1:0] data_r;
  logic              valid_r;
  logic              busy_r;
  logic              done_r;
  logic [31:0]       sent_r;
  logic [31:0]       wrap_r;
  logic              cont_r;
  logic [31:0]       count_r;
  logic [GAP_W-1:0]  gap_len_r;
  logic [GAP_W-1:0]  gap_cnt_r;
  logic              stop_r;

  logic              transfer_s;
  logic              stop_seen_s;
  logic              data_is_ones_s;
  logic [DATA_W-1:0] data_inc_s;
  logic [31:0]       sent_inc_s;
  logic              last_word_s;
  logic              gap_enabled_s;
  logic              gap_last_s;

  // A word is accepted whenever the pending word meets FIFO readiness.
  assign transfer_s     = valid_r & wr_if.wr_ready;
  // A stop seen now or earlier in this run ends it at the next opportunity.
  assign stop_seen_s    = stop_r | stop;
  assign data_is_ones_s = (data_r == {DATA_W{1'b1}});
  assign data_inc_s     = data_r + {{(DATA_W-1){1'b0}}, 1'b1};
  assign sent_inc_s     = sent_r + 32'd1;
  // The current transfer is the final one on a stop or on reaching the bound.
  assign last_word_s    = stop_seen_s | (~cont_r & (sent_inc_s == count_r));
  assign gap_enabled_s  = (gap_len_r != {GAP_W{1'b0}});
  assign gap_last_s     = (gap_cnt_r == {{(GAP_W-1){1'b0}}, 1'b1});

  // Run sequencer: start/stop/gap control, stream word and run statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      data_r    <= INIT_VALUE;
      valid_r   <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      sent_r    <= 32'd0;
      wrap_r    <= 32'd0;
      cont_r    <= 1'b0;
      count_r   <= 32'd0;
      gap_len_r <= {GAP_W{1'b0}};
      gap_cnt_r <= {GAP_W{1'b0}};
      stop_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // stop is meaningless here; only start is looked at
          if (start) begin
            cont_r    <= continuous;
            count_r   <= word_count;
            gap_len_r <= gap_cycles;
            sent_r    <= 32'd0;
            wrap_r    <= 32'd0;
            stop_r    <= 1'b0;
            data_r    <= INIT_VALUE;
            if (!continuous && (word_count == 32'd0)) begin
              // empty bounded run: finish immediately without a word
              done_r <= 1'b1;
            end else begin
              state_r <= ST_RUN;
              valid_r <= 1'b1;
              busy_r  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (transfer_s) begin
            sent_r <= sent_inc_s;
            if (data_is_ones_s) begin
              wrap_r <= wrap_r + 32'd1;
            end
            if (last_word_s) begin
              state_r <= ST_IDLE;
              valid_r <= 1'b0;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              data_r <= data_inc_s;
              if (gap_enabled_s) begin
                state_r   <= ST_GAP;
                valid_r   <= 1'b0;
                gap_cnt_r <= gap_len_r;
              end
            end
          end else begin
            // pending word is held; remember any stop until it is accepted
            stop_r <= stop_seen_s;
          end
        end
        ST_GAP: begin
          if (stop_seen_s) begin
            state_r <= ST_IDLE;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else if (gap_last_s) begin
            state_r <= ST_RUN;
            valid_r <= 1'b1;
          end else begin
            gap_cnt_r <= gap_cnt_r - {{(GAP_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_r <= ST_IDLE;
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign wr_if.wr_data       = data_r;
  assign wr_if.wr_data_valid = valid_r;
  assign busy                = busy_r;
  assign done                = done_r;
  assign words_sent          = sent_r;
  assign wrap_count          = wrap_r;

endmodule

// File: tb/tb_fifo_test_pattern_gen.sv
// Bench for fifo_test_pattern_gen: two instances (start word 0 and start word
// FFFFFFFE) share all stimulus. A cycle-level run model tracks each instance,
// a vector table covers the basic runs, hand sequences cover the multi-cycle
// corner cases, and a random phase exercises everything against the model.
module tb_fifo_test_pattern_gen;

  localparam int          DATA_W = 32;
  localparam int          GAP_W  = 8;
  localparam logic [31:0] INIT_A = 32'h0000_0000;
  localparam logic [31:0] INIT_B = 32'hFFFF_FFFE;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        continuous = 1'b0;
  logic        rdy = 1'b0;
  logic [31:0] word_count = 32'd0;
  logic [7:0]  gap_cycles = 8'd0;

  logic        busy_a, done_a, busy_b, done_b;
  logic [31:0] sent_a, wrap_a, sent_b, wrap_b;

  fifo_test_pattern_gen_if #(.DATA_W(DATA_W)) if_a ();
  fifo_test_pattern_gen_if #(.DATA_W(DATA_W)) if_b ();
  assign if_a.wr_ready = rdy;
  assign if_b.wr_ready = rdy;

  fifo_test_pattern_gen #(.DATA_W(DATA_W), .INIT_VALUE(INIT_A), .GAP_W(GAP_W)) dut_a (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .continuous(continuous),
    .word_count(word_count), .gap_cycles(gap_cycles), .wr_if(if_a),
    .busy(busy_a), .done(done_a), .words_sent(sent_a), .wrap_count(wrap_a)
  );

  fifo_test_pattern_gen #(.DATA_W(DATA_W), .INIT_VALUE(INIT_B), .GAP_W(GAP_W)) dut_b (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .continuous(continuous),
    .word_count(word_count), .gap_cycles(gap_cycles), .wr_if(if_b),
    .busy(busy_b), .done(done_b), .words_sent(sent_b), .wrap_count(wrap_b)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- run model ----------------
  // A run is described by how many words have been accepted (the visible word
  // is always start word + accepted count), how many idle gap cycles remain,
  // and whether a stop has been requested.
  logic        m_run = 1'b0, m_valid = 1'b0, m_done = 1'b0, m_stop = 1'b0, m_cont = 1'b0;
  int          m_gap = 0, m_gap_left = 0;
  logic [31:0] m_wc = 32'd0, m_sent = 32'd0, m_wraps_a = 32'd0, m_wraps_b = 32'd0;

  task automatic model_finish_run();
    m_run = 1'b0; m_valid = 1'b0; m_done = 1'b1;
  endtask

  task automatic model_step();
    logic [31:0] w_a, w_b;
    if (rst) begin
      m_run = 1'b0; m_valid = 1'b0; m_done = 1'b0; m_stop = 1'b0;
      m_gap_left = 0; m_sent = 32'd0; m_wraps_a = 32'd0; m_wraps_b = 32'd0;
    end else begin
      m_done = 1'b0;
      if (!m_run) begin
        if (start) begin
          m_cont = continuous; m_wc = word_count; m_gap = int'(gap_cycles);
          m_sent = 32'd0; m_wraps_a = 32'd0; m_wraps_b = 32'd0; m_stop = 1'b0;
          if (!continuous && word_count == 32'd0) m_done = 1'b1;
          else begin m_run = 1'b1; m_valid = 1'b1; m_gap_left = 0; end
        end
      end else if (m_gap_left > 0) begin
        if (m_stop || stop) model_finish_run();
        else begin
          m_gap_left--;
          if (m_gap_left == 0) m_valid = 1'b1;
        end
      end else if (rdy) begin
        w_a = INIT_A + m_sent;
        w_b = INIT_B + m_sent;
        if (w_a == 32'hFFFF_FFFF) m_wraps_a++;
        if (w_b == 32'hFFFF_FFFF) m_wraps_b++;
        m_sent++;
        if (m_stop || stop || (!m_cont && m_sent == m_wc)) model_finish_run();
        else if (m_gap > 0) begin m_gap_left = m_gap; m_valid = 1'b0; end
      end else begin
        m_stop = m_stop || stop;
      end
    end
  endtask

  task automatic model_check();
    chk("m_valid_a", if_a.wr_data_valid, m_valid);
    chk("m_busy_a", busy_a, m_run);
    chk("m_done_a", done_a, m_done);
    chk("m_sent_a", sent_a, m_sent);
    chk("m_wrap_a", wrap_a, m_wraps_a);
    chk("m_valid_b", if_b.wr_data_valid, m_valid);
    chk("m_busy_b", busy_b, m_run);
    chk("m_done_b", done_b, m_done);
    chk("m_sent_b", sent_b, m_sent);
    chk("m_wrap_b", wrap_b, m_wraps_b);
    if (m_valid) begin
      chk("m_data_a", if_a.wr_data, INIT_A + m_sent);
      chk("m_data_b", if_b.wr_data, INIT_B + m_sent);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    model_check();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        start, stop, rdy, cont;
    logic [31:0] wc;
    logic [7:0]  gap;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic        exp_busy, exp_done;
    logic [31:0] exp_sent;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic st, logic rd, logic [31:0] wc, logic [7:0] gp,
                              logic ev, logic [31:0] ed, logic eb, logic edn, logic [31:0] es);
    vec_t v;
    v.start = st; v.stop = 1'b0; v.rdy = rd; v.cont = 1'b0; v.wc = wc; v.gap = gp;
    v.exp_valid = ev; v.exp_data = ed; v.exp_busy = eb; v.exp_done = edn; v.exp_sent = es;
    return v;
  endfunction

  initial begin
    // bounded run of 5, no backpressure
    vq.push_back(mk(1, 1, 5, 0, 1, 0, 1, 0, 0));
    vq.push_back(mk(0, 1, 5, 0, 1, 1, 1, 0, 1));
    vq.push_back(mk(0, 1, 5, 0, 1, 2, 1, 0, 2));
    vq.push_back(mk(0, 1, 5, 0, 1, 3, 1, 0, 3));
    vq.push_back(mk(0, 1, 5, 0, 1, 4, 1, 0, 4));
    vq.push_back(mk(0, 1, 5, 0, 0, 0, 0, 1, 5));
    vq.push_back(mk(0, 1, 5, 0, 0, 0, 0, 0, 5));
    // backpressure on word 1 for 3 cycles
    vq.push_back(mk(1, 1, 4, 0, 1, 0, 1, 0, 0));
    vq.push_back(mk(0, 1, 4, 0, 1, 1, 1, 0, 1));
    vq.push_back(mk(0, 0, 4, 0, 1, 1, 1, 0, 1));
    vq.push_back(mk(0, 0, 4, 0, 1, 1, 1, 0, 1));
    vq.push_back(mk(0, 0, 4, 0, 1, 1, 1, 0, 1));
    vq.push_back(mk(0, 1, 4, 0, 1, 2, 1, 0, 2));
    vq.push_back(mk(0, 1, 4, 0, 1, 3, 1, 0, 3));
    vq.push_back(mk(0, 1, 4, 0, 0, 0, 0, 1, 4));
    vq.push_back(mk(0, 1, 4, 0, 0, 0, 0, 0, 4));
    // 3 words with a 2-cycle gap, no gap after the last word
    vq.push_back(mk(1, 1, 3, 2, 1, 0, 1, 0, 0));
    vq.push_back(mk(0, 1, 3, 2, 0, 0, 1, 0, 1));
    vq.push_back(mk(0, 1, 3, 2, 0, 0, 1, 0, 1));
    vq.push_back(mk(0, 1, 3, 2, 1, 1, 1, 0, 1));
    vq.push_back(mk(0, 1, 3, 2, 0, 0, 1, 0, 2));
    vq.push_back(mk(0, 1, 3, 2, 0, 0, 1, 0, 2));
    vq.push_back(mk(0, 1, 3, 2, 1, 2, 1, 0, 2));
    vq.push_back(mk(0, 1, 3, 2, 0, 0, 0, 1, 3));
    vq.push_back(mk(0, 1, 3, 2, 0, 0, 0, 0, 3));

    // reset
    rst = 1'b1;
    tick();
    tick();
    chk("rst_data_a", if_a.wr_data, INIT_A);
    chk("rst_data_b", if_b.wr_data, INIT_B);
    chk("rst_valid_a", if_a.wr_data_valid, 1'b0);
    rst = 1'b0;
    tick();

    foreach (vq[i]) begin
      start = vq[i].start; stop = vq[i].stop; rdy = vq[i].rdy;
      continuous = vq[i].cont; word_count = vq[i].wc; gap_cycles = vq[i].gap;
      tick();
      chk($sformatf("tbl%0d_valid", i), if_a.wr_data_valid, vq[i].exp_valid);
      chk($sformatf("tbl%0d_busy", i), busy_a, vq[i].exp_busy);
      chk($sformatf("tbl%0d_done", i), done_a, vq[i].exp_done);
      chk($sformatf("tbl%0d_sent", i), sent_a, vq[i].exp_sent);
      if (vq[i].exp_valid) chk($sformatf("tbl%0d_data", i), if_a.wr_data, vq[i].exp_data);
    end

    // wrap through all-ones on the FFFFFFFE instance
    start = 1'b1; stop = 1'b0; rdy = 1'b1; continuous = 1'b0; word_count = 32'd4; gap_cycles = 8'd0;
    tick();
    start = 1'b0;
    chk("wrap_d0", if_b.wr_data, 32'hFFFF_FFFE);
    tick();
    chk("wrap_d1", if_b.wr_data, 32'hFFFF_FFFF);
    tick();
    chk("wrap_d2", if_b.wr_data, 32'h0000_0000);
    tick();
    chk("wrap_d3", if_b.wr_data, 32'h0000_0001);
    tick();
    chk("wrap_done", done_b, 1'b1);
    chk("wrap_count_b", wrap_b, 32'd1);
    chk("wrap_count_a", wrap_a, 32'd0);
    chk("wrap_sent", sent_b, 32'd4);
    tick();

    // continuous run stopped under backpressure; start while busy ignored
    start = 1'b1; continuous = 1'b1; word_count = 32'd3; rdy = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    chk("stop_pre_data", if_a.wr_data, 32'd7);
    chk("stop_pre_sent", sent_a, 32'd7);
    rdy = 1'b0; stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_hold_data", if_a.wr_data, 32'd7);
    chk("stop_hold_valid", if_a.wr_data_valid, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_start_sent", sent_a, 32'd7);
    chk("busy_start_busy", busy_a, 1'b1);
    tick();
    chk("stop_hold2_data", if_a.wr_data, 32'd7);
    rdy = 1'b1;
    tick();
    chk("stop_done", done_a, 1'b1);
    chk("stop_sent", sent_a, 32'd8);
    chk("stop_valid", if_a.wr_data_valid, 1'b0);
    tick();
    chk("stop_done_pulse", done_a, 1'b0);

    // empty bounded run
    start = 1'b1; continuous = 1'b0; word_count = 32'd0;
    tick();
    start = 1'b0;
    chk("zero_done", done_a, 1'b1);
    chk("zero_valid", if_a.wr_data_valid, 1'b0);
    chk("zero_busy", busy_a, 1'b0);
    tick();
    chk("zero_done_pulse", done_a, 1'b0);
    chk("zero_valid2", if_a.wr_data_valid, 1'b0);

    // reset in the middle of a run
    start = 1'b1; word_count = 32'd10;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("mid_sent", sent_a, 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", if_a.wr_data_valid, 1'b0);
    chk("mid_rst_sent", sent_a, 32'd0);
    chk("mid_rst_busy", busy_a, 1'b0);
    chk("mid_rst_done", done_a, 1'b0);
    tick();
    chk("mid_rst_done2", done_a, 1'b0);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst        = ($urandom_range(299) == 0);
      start      = ($urandom_range(5) == 0);
      stop       = ($urandom_range(24) == 0);
      rdy        = ($urandom_range(9) < 7);
      continuous = ($urandom_range(7) == 0);
      word_count = 32'($urandom_range(6));
      gap_cycles = 8'($urandom_range(3));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
